sd_rd_block: RTL and testbench

- SPI-mode SD single-block read engine (CMD17); the responder for the photo reader's sector-read requests.
- Accepts a start request and a 32-bit sector address, then clocks one 512-byte block off the card.
- Streams the block out as 256 16-bit words with a valid strobe, asserting busy for the whole transaction.
- Sits between the photo read sequencer and the SD card pins; card initialisation is done by a separate block, which signals sd_init_done.

---
 rtl/sd_rd_block.sv | 249 ++++++++++++++++++++++++
 tb/tb_sd_rd_block.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_rd_block.sv
// sd_rd_block: SPI-mode SD single-block read engine (CMD17).
// Accepts a start edge and a 32-bit block address, reads one 512-byte block
// and streams it out as 256 16-bit words (first card byte in [15:8]).
// Optional build macro SD_RD_CRC_CHECK_EN: when defined, the data CRC16-CCITT
// is checked and a mismatch raises rd_err during POST.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for an accepted start edge
// PRE    | CS low, 8 SCLK with MOSI high
// CMD    | shift 0x51, address, 0xFF (48 bits, MSB first)
// R1     | poll bytes until MSB=0; 0x00 -> TOKEN, else / timeout -> ERR
// TOKEN  | poll bytes for 0xFE; timeout -> ERR
// DATA   | 4096 data bits, one word strobe every 16 bits
// CRC    | 16 CRC bits
// POST   | 8 SCLK with MOSI high, then CS high
// END    | one clk with CS high and busy still set
// ERR    | one-clk rd_err pulse, then POST
module sd_rd_block #(
    parameter int CLK_DIV       = 2,
    parameter int R1_TIMEOUT    = 16,
    parameter int TOKEN_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_init_done,
    input  logic        rd_start_en,
    input  logic [31:0] rd_sec_addr,
    output logic        rd_busy,
    output logic        rd_val_en,
    output logic [15:0] rd_val_data,
    output logic        rd_err,
    output logic        sd_cs,
    output logic        sd_sclk,
    output logic        sd_mosi,
    input  logic        sd_miso
);

    localparam int TO_MAX = (R1_TIMEOUT > TOKEN_TIMEOUT) ? R1_TIMEOUT : TOKEN_TIMEOUT;
    localparam int BW     = $clog2(TO_MAX + 1);
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_POST, S_END, S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_div;
    logic            r_sclk;
    logic            r_start_q;
    logic            r_start_qq;
    logic [47:0]     r_cmd;
    logic [15:0]     r_rx;
    logic [12:0]     r_bit_cnt;
    logic [BW-1:0]   r_byte_cnt;
    logic            r_val_en;
    logic [15:0]     r_val_data;

    logic            w_active;
    logic            w_tick;
    logic            w_rise;
    logic            w_fall;
    logic            w_accept;
    logic            w_byte_done;
    logic            w_entry;
    logic            w_busy;
    logic            w_cs_n;
    logic            w_mosi;
    logic            w_err;

    // SCLK runs only while the card is being clocked; ERR/END/IDLE keep it low.
    assign w_active    = (r_state == S_PRE)  || (r_state == S_CMD)  || (r_state == S_R1) ||
                         (r_state == S_TOKEN) || (r_state == S_DATA) || (r_state == S_CRC) ||
                         (r_state == S_POST);
    assign w_tick      = w_active && (r_div == '0);
    assign w_rise      = w_tick && !r_sclk;
    assign w_fall      = w_tick && r_sclk;
    assign w_accept    = (r_state == S_IDLE) && sd_init_done && r_start_q && !r_start_qq;
    assign w_byte_done = w_fall && (r_bit_cnt[2:0] == 3'd7);
    assign w_entry     = (w_state_nxt != r_state);

    // Register and edge-detect the start request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_q  <= 1'b0;
            r_start_qq <= 1'b0;
        end else begin
            r_start_q  <= rd_start_en;
            r_start_qq <= r_start_q;
        end
    end

    // SCLK divider; every bit is a rising tick then a falling tick, so states change with SCLK low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= DIV_LOAD;
            r_sclk <= 1'b0;
        end else if (!w_active) begin
            r_div  <= DIV_LOAD;
            r_sclk <= 1'b0;
        end else if (r_div == '0) begin
            r_div  <= DIV_LOAD;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div - 1'b1;
        end
    end

    // Command frame latched on accept, shifted out after each falling edge in CMD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd <= '1;
        end else if (w_accept) begin
            r_cmd <= {8'h51, rd_sec_addr, 8'hFF};
        end else if ((r_state == S_CMD) && w_fall) begin
            r_cmd <= {r_cmd[46:0], 1'b1};
        end
    end

    // MISO shift register, sampled on the SCLK rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx <= '0;
        end else if (w_rise) begin
            r_rx <= {r_rx[14:0], sd_miso};
        end
    end

    // Bit/byte counters: cleared on every state entry; polling states restart bits per byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
        end else if (w_entry) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
        end else if (w_fall) begin
            if (((r_state == S_R1) || (r_state == S_TOKEN)) && w_byte_done) begin
                r_bit_cnt  <= '0;
                r_byte_cnt <= r_byte_cnt + BW'(1);
            end else begin
                r_bit_cnt  <= r_bit_cnt + 13'd1;
            end
        end
    end

    // Word strobe after every 16th data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val_en   <= 1'b0;
            r_val_data <= '0;
        end else begin
            r_val_en <= 1'b0;
            if ((r_state == S_DATA) && w_fall && (r_bit_cnt[3:0] == 4'hF)) begin
                r_val_en   <= 1'b1;
                r_val_data <= r_rx;
            end
        end
    end

`ifdef SD_RD_CRC_CHECK_EN
    logic [15:0] r_crc;
    logic        r_crc_err;
    logic        w_crc_fb;

    assign w_crc_fb = r_crc[15] ^ sd_miso;

    // Serial CRC16-CCITT over the data bits; mismatch pulses on the first POST clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc     <= '0;
            r_crc_err <= 1'b0;
        end else begin
            if (w_entry && (w_state_nxt == S_DATA)) begin
                r_crc <= '0;
            end else if ((r_state == S_DATA) && w_rise) begin
                r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
            end
            r_crc_err <= (r_state == S_CRC) && (w_state_nxt == S_POST) && (r_rx != r_crc);
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; bit-level transitions happen on the falling SCLK tick.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_PRE;
            S_PRE:   if (w_fall && (r_bit_cnt == 13'd7)) w_state_nxt = S_CMD;
            S_CMD:   if (w_fall && (r_bit_cnt == 13'd47)) w_state_nxt = S_R1;
            S_R1: begin
                if (w_byte_done) begin
                    if (!r_rx[7]) begin
                        w_state_nxt = (r_rx[7:0] == 8'h00) ? S_TOKEN : S_ERR;
                    end else if (r_byte_cnt == BW'(R1_TIMEOUT - 1)) begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_TOKEN: begin
                if (w_byte_done) begin
                    if (r_rx[7:0] == 8'hFE) begin
                        w_state_nxt = S_DATA;
                    end else if (r_byte_cnt == BW'(TOKEN_TIMEOUT - 1)) begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_DATA:  if (w_fall && (r_bit_cnt == 13'd4095)) w_state_nxt = S_CRC;
            S_CRC:   if (w_fall && (r_bit_cnt == 13'd15)) w_state_nxt = S_POST;
            S_POST:  if (w_fall && (r_bit_cnt == 13'd7)) w_state_nxt = S_END;
            S_END:   w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_POST;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from state; CS stays low through ERR so POST can close the frame.
    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_cs_n = !(w_active || (r_state == S_ERR));
        w_mosi = (r_state == S_CMD) ? r_cmd[47] : 1'b1;
`ifdef SD_RD_CRC_CHECK_EN
        w_err  = (r_state == S_ERR) || r_crc_err;
`else
        w_err  = (r_state == S_ERR);
`endif
    end

    assign rd_busy     = w_busy;
    assign rd_val_en   = r_val_en;
    assign rd_val_data = r_val_data;
    assign rd_err      = w_err;
    assign sd_cs       = w_cs_n;
    assign sd_sclk     = r_sclk;
    assign sd_mosi     = w_mosi;

endmodule

// File: tb/tb_sd_rd_block.sv
// Directed testbench for sd_rd_block with a simple SPI card model.
module tb_sd_rd_block;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sd_init_done = 1'b0;
    logic        rd_start_en = 1'b0;
    logic [31:0] rd_sec_addr = '0;
    logic        rd_busy;
    logic        rd_val_en;
    logic [15:0] rd_val_data;
    logic        rd_err;
    logic        sd_cs;
    logic        sd_sclk;
    logic        sd_mosi;
    logic        sd_miso = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  resp[$];
    logic [15:0] words[$];
    int          n_err_pulse = 0;
    int          np = 0;
    int          nf = 0;
    int          err_np = 0;
    logic [47:0] cmd_cap = '0;

    sd_rd_block #(
        .CLK_DIV       (1),
        .R1_TIMEOUT    (16),
        .TOKEN_TIMEOUT (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sd_init_done (sd_init_done),
        .rd_start_en  (rd_start_en),
        .rd_sec_addr  (rd_sec_addr),
        .rd_busy      (rd_busy),
        .rd_val_en    (rd_val_en),
        .rd_val_data  (rd_val_data),
        .rd_err       (rd_err),
        .sd_cs        (sd_cs),
        .sd_sclk      (sd_sclk),
        .sd_mosi      (sd_mosi),
        .sd_miso      (sd_miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic resp_bit(input int i);
        if ((i / 8) < resp.size()) return resp[i / 8][7 - (i % 8)];
        return 1'b1;
    endfunction

    // Card: captures the command after 8 lead-in clocks, answers from resp after the 56th clock.
    always @(posedge sd_sclk or negedge sd_sclk or posedge sd_cs) begin
        if (sd_cs) begin
            np = 0;
            nf = 0;
            sd_miso = 1'b1;
        end else if (sd_sclk) begin
            np++;
            if (np >= 9 && np <= 56) cmd_cap = {cmd_cap[46:0], sd_mosi};
        end else begin
            nf++;
            if (nf >= 56) sd_miso = resp_bit(nf - 56);
        end
    end

    always @(negedge clk) begin
        if (rd_val_en) words.push_back(rd_val_data);
        if (rd_err) begin
            n_err_pulse++;
            err_np = np;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic build(input int r1_lead, input logic [7:0] r1, input int tok_lead,
                         input bit with_data, input bit flip_crc);
        logic [15:0] crc;
        logic [7:0]  b;
        logic        fb;
        resp.delete();
        repeat (r1_lead) resp.push_back(8'hFF);
        resp.push_back(r1);
        if (with_data) begin
            repeat (tok_lead) resp.push_back(8'hFF);
            resp.push_back(8'hFE);
            crc = '0;
            for (int k = 0; k < 512; k++) begin
                b = k[7:0];
                resp.push_back(b);
                for (int j = 7; j >= 0; j--) begin
                    fb  = crc[15] ^ b[j];
                    crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
                end
            end
            if (flip_crc) crc = crc ^ 16'h0001;
            resp.push_back(crc[15:8]);
            resp.push_back(crc[7:0]);
        end
    endtask

    task automatic request(input logic [31:0] addr, input string tag);
        rd_sec_addr = addr;
        rd_start_en = 1'b1;
        tick(3);
        check({tag, "_busy_rise"}, rd_busy, 1);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (rd_busy && n < max_cyc) begin
            tick(1);
            n++;
        end
        check({tag, "_done"}, rd_busy, 0);
    endtask

    task automatic wait_words(input int target, input int base, input int max_cyc, input string tag);
        int n = 0;
        while ((words.size() - base) < target && n < max_cyc) begin
            tick(1);
            n++;
        end
        check({tag, "_words_reached"}, words.size() - base, target);
    endtask

    initial begin
        int base;
        int e0;

        #12;
        check("rst_ctrl", {rd_busy, rd_val_en, rd_err, sd_cs, sd_sclk, sd_mosi}, 6'b000101);
        check("rst_data", rd_val_data, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // Request while card not initialised is dropped.
        rd_start_en = 1'b1;
        tick(20);
        check("gate_busy", rd_busy, 0);
        check("gate_cs", sd_cs, 1);
        rd_start_en = 1'b0;
        tick(2);
        sd_init_done = 1'b1;
        tick(2);

        // Normal read, with a second edge mid-transfer and level held after completion.
        build(2, 8'h00, 10, 1'b1, 1'b0);
        base = words.size();
        e0 = n_err_pulse;
        request(32'h0000_1234, "norm");
        wait_words(50, base, 5000, "norm_mid");
        rd_start_en = 1'b0;
        tick(3);
        rd_start_en = 1'b1;
        wait_idle(20000, "norm");
        check("norm_cmd", cmd_cap, {8'h51, 32'h0000_1234, 8'hFF});
        check("norm_count", words.size() - base, 256);
        check("norm_w0", words[base], 16'h0001);
        check("norm_w100", words[base + 100], 16'hC8C9);
        check("norm_w255", words[base + 255], 16'hFEFF);
        check("norm_err", n_err_pulse - e0, 0);
        check("norm_cs", sd_cs, 1);
        tick(50);
        check("noretrig_busy", rd_busy, 0);
        check("noretrig_count", words.size() - base, 256);
        rd_start_en = 1'b0;
        tick(2);

        // Bad R1.
        build(1, 8'h05, 0, 1'b0, 1'b0);
        base = words.size();
        e0 = n_err_pulse;
        request(32'hA5A5_0F0F, "badr1");
        wait_idle(2000, "badr1");
        check("badr1_cmd", cmd_cap, {8'h51, 32'hA5A5_0F0F, 8'hFF});
        check("badr1_err", n_err_pulse - e0, 1);
        check("badr1_words", words.size() - base, 0);
        check("badr1_cs", sd_cs, 1);
        rd_start_en = 1'b0;
        tick(2);

        // Next request after an error succeeds.
        build(2, 8'h00, 10, 1'b1, 1'b0);
        base = words.size();
        e0 = n_err_pulse;
        request(32'h0000_0001, "rec");
        wait_idle(20000, "rec");
        check("rec_count", words.size() - base, 256);
        check("rec_w255", words[base + 255], 16'hFEFF);
        check("rec_err", n_err_pulse - e0, 0);
        rd_start_en = 1'b0;
        tick(2);

        // R1 timeout: MISO high forever, 16 polled bytes -> 56 + 128 SCLK.
        resp.delete();
        base = words.size();
        e0 = n_err_pulse;
        request(32'h0000_0002, "r1to");
        wait_idle(2000, "r1to");
        check("r1to_err", n_err_pulse - e0, 1);
        check("r1to_sclks", err_np, 184);
        check("r1to_words", words.size() - base, 0);
        rd_start_en = 1'b0;
        tick(2);

        // Token timeout: R1 ok, then 32 bytes of 0xFF -> 56 + 16 + 256 SCLK.
        build(1, 8'h00, 0, 1'b0, 1'b0);
        base = words.size();
        e0 = n_err_pulse;
        request(32'h0000_0003, "tokto");
        wait_idle(2000, "tokto");
        check("tokto_err", n_err_pulse - e0, 1);
        check("tokto_sclks", err_np, 328);
        check("tokto_words", words.size() - base, 0);
        rd_start_en = 1'b0;
        tick(2);

        // Reset mid-DATA, then a fresh read.
        build(2, 8'h00, 10, 1'b1, 1'b0);
        base = words.size();
        e0 = n_err_pulse;
        request(32'h0000_0004, "rstmid");
        wait_words(100, base, 5000, "rstmid");
        #2;
        rst = 1'b1;
        rd_start_en = 1'b0;
        #1;
        check("rstmid_ctrl", {rd_busy, rd_val_en, rd_err, sd_cs, sd_sclk, sd_mosi}, 6'b000101);
        check("rstmid_data", rd_val_data, 16'h0000);
        tick(3);
        check("rstmid_words", words.size() - base, 100);
        check("rstmid_err", n_err_pulse - e0, 0);
        rst = 1'b0;
        tick(3);
        build(2, 8'h00, 10, 1'b1, 1'b0);
        base = words.size();
        request(32'h0000_0005, "after");
        wait_idle(20000, "after");
        check("after_count", words.size() - base, 256);
        check("after_w0", words[base], 16'h0001);
        check("after_w255", words[base + 255], 16'hFEFF);
        check("after_err", n_err_pulse - e0, 0);
        rd_start_en = 1'b0;
        tick(2);

        // Corrupted CRC: data still delivered; error only when the check is built in.
        build(2, 8'h00, 10, 1'b1, 1'b1);
        base = words.size();
        e0 = n_err_pulse;
        request(32'h0000_0006, "crc");
        wait_idle(20000, "crc");
        check("crc_count", words.size() - base, 256);
`ifdef SD_RD_CRC_CHECK_EN
        check("crc_err", n_err_pulse - e0, 1);
`else
        check("crc_err", n_err_pulse - e0, 0);
`endif
        rd_start_en = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
